// File: rtl/imem_fetch_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_pkg
// Shared definitions for the instruction-fetch front end and main memory:
// memory direction encodings, the default boot address, fetch FSM state
// encodings and the FIFO entry layout.
// -----------------------------------------------------------------------------
package imem_fetch_pkg;

  // Main memory direction encodings.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // First fetch address after reset.
  localparam logic [31:0] DEFAULT_STARTING_ADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small in-order FIFO of fetched words. The head entry is presented
// combinationally; flush empties the FIFO and overrides push/pop.
//
// Ports
//   clock, reset_n  : clock and asynchronous active-low reset
//   flush_i         : discard all entries this edge
//   push_i / pop_i  : write tail / release head (pop ignored when empty,
//                     push ignored when full unless a pop frees a slot)
//   push_entry_i    : entry written on push
//   head_entry_o    : current head entry (meaningless when count_o == 0)
//   count_o         : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             push_entry_i,
  output fetch_entry_t             head_entry_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned       PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(DEPTH);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != COUNT_FULL) || do_pop);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are
  // valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_entry_o = mem_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/imem_fetch.sv
// -----------------------------------------------------------------------------
// imem_fetch
// Instruction fetch front end: walks a fetch PC through main memory one word
// per cycle, queues {word, pc} pairs in a small FIFO and hands them to the
// consumer with a valid/ready handshake. A redirect flushes the queue and
// restarts the stream at a new word-aligned address.
//
// Ports
//   clock, reset_n            : clock and asynchronous active-low reset
//   enable                    : permit fetching
//   mem_address               : byte address to main memory (always fetch PC)
//   mem_data_in               : write data to main memory, tied to zero
//   mem_read_write            : main memory direction, tied to READ
//   mem_data_out              : word read back combinationally from memory
//   redirect_valid/_pc        : restart the stream at redirect_pc
//   inst_valid/_data/_pc      : FIFO head presented to the consumer
//   inst_ready                : consumer accepts the head this cycle
// -----------------------------------------------------------------------------
module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR = DEFAULT_STARTING_ADDR,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned    CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   fifo_count;
  fetch_entry_t       head_entry;
  logic               push, pop, full;

  assign full = (fifo_count == COUNT_FULL);
  assign pop  = inst_valid && inst_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i ('{data: mem_data_out, pc: fetch_pc_q}),
    .head_entry_o (head_entry),
    .count_o      (fifo_count)
  );

  // State register and fetch PC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= STARTING_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state logic. A full FIFO only stalls when the head is not being
  // consumed this cycle; with a pop the slot is recycled and fetch continues.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect_valid) fetch_pc_d = word_align(redirect_pc);
    else if (push)      fetch_pc_d = fetch_pc_q + 32'd4;  // wraps mod 2^32

    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH: begin
        if (!enable)                            state_d = IDLE;
        else if (!redirect_valid && full && !pop) state_d = STALL;
      end
      STALL: begin
        if (!enable)                    state_d = IDLE;
        else if (redirect_valid || pop) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Redirect suppresses the push so the flushed FIFO stays empty.
  always_comb begin
    push           = 1'b0;
    if ((state_q == FETCH) && !redirect_valid) push = !full || pop;
    mem_address    = fetch_pc_q;
    mem_data_in    = 32'h0;
    mem_read_write = MEM_READ;
    inst_valid     = (fifo_count != '0);
    inst_data      = head_entry.data;
    inst_pc        = head_entry.pc;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter STARTING_ADDR, default 'h01000000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of fetched-word entries (power of two, at least 2).
REQ-003 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port enable  input  1  permits fetching when high.
REQ-006 Port mem_address  output  32  is the byte address presented to mainmem.
REQ-007 Port mem_data_in  output  32  is the write data to mainmem, constant 32'h0.
REQ-008 Port mem_read_write  output  1  is the mainmem direction, constant READ (0).
REQ-009 Port mem_data_out  input  32  is the read word returned by mainmem, combinational from mem_address.
REQ-010 Port redirect_valid  input  1  requests a fetch-stream restart.
REQ-011 Port redirect_pc  input  32  is the restart address.
REQ-012 Port inst_valid  output  1  flags that the FIFO head holds a word.
REQ-013 Port inst_data  output  32  is the FIFO-head instruction word.
REQ-014 Port inst_pc  output  32  is the FIFO-head fetch address.
REQ-015 Port inst_ready  input  1  is the consumer accept; pop occurs when inst_valid and inst_ready are both high.

Function
REQ-016 States: IDLE, FETCH, STALL.
- IDLE->FETCH when enable=1.
- FETCH->STALL when the FIFO becomes full with no pop.
- STALL->FETCH on a pop.
- FETCH/STALL->IDLE when enable=0.
REQ-017 mem_address shall equal fetch_pc in every state.
REQ-018 In FETCH, a push shall occur when count<FIFO_DEPTH, or when count=FIFO_DEPTH and a pop occurs the same cycle.
REQ-019 On a push, {mem_data_out, fetch_pc} is written to the FIFO tail at the edge and fetch_pc advances by 4; read latency is 1 cycle, so a word is visible on inst_* the cycle after its address is driven.
REQ-020 No push occurs in IDLE or STALL; fetch_pc holds.
REQ-021 Simultaneous push and pop shall leave count unchanged and keep the FIFO in order.
REQ-022 fetch_pc arithmetic is 32-bit modulo 2^32: 32'hFFFFFFFC+4 = 32'h0. No range check is performed.
REQ-023 redirect_valid has priority over push and pop: the FIFO is flushed (count=0), fetch_pc is loaded with {redirect_pc[31:2],2'b00}, no push occurs that cycle, and inst_valid is 0 the following cycle.
REQ-024 A redirect in STALL shall move the state to FETCH if enable=1, otherwise to IDLE.
REQ-025 A redirect while enable=0 shall update fetch_pc and remain in IDLE.
REQ-026 inst_data and inst_pc are don't-care when inst_valid=0.
REQ-027 inst_valid=1 iff count>0; the FIFO head shall be stable while inst_valid=1 and inst_ready=0.

Reset
REQ-028 While reset_n=0, the block shall hold: state=IDLE, fetch_pc=STARTING_ADDR, count=0, inst_valid=0, mem_address=STARTING_ADDR, mem_read_write=0, mem_data_in=0.
REQ-029 Assertion of reset_n mid-operation shall discard FIFO contents immediately.
REQ-030 The first push shall occur no earlier than the first rising edge after reset_n deasserts with enable=1.

Structure
REQ-031 READ/WRITE encodings, STARTING_ADDR default and state encodings shall live in the shared package used with mainmem.
REQ-032 FIFO storage, pointers and count shall be a sub-module fetch_fifo; the top level holds the FSM and fetch_pc.

Verification
REQ-033 The bench shall connect to a mainmem instance loaded with words W[i] = i.
REQ-034 Reset, enable=1, inst_ready=1 for 8 cycles -> inst_pc sequence 01000000, 01000004, ... with inst_data 0,1,2,...; one word per cycle after a 1-cycle latency.
REQ-035 inst_ready=0 from reset -> exactly 4 pushes, state STALL, mem_address=01000010 held; a single pop -> one push of the word at 01000010.
REQ-036 Redirect to 01000043 with 3 entries queued -> next cycle inst_valid=0, then inst_pc=01000040, inst_data=16.
REQ-037 redirect_pc=FFFFFFFC with no memory check -> inst_pc sequence FFFFFFFC, 00000000.
REQ-038 reset_n pulsed low mid-FETCH with 2 entries queued -> inst_valid=0 immediately; after release the stream restarts at 01000000.
REQ-039 Full FIFO with inst_ready=1 -> one push and one pop per cycle, count stays 4, no entry skipped or duplicated.
